// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader: FSM encoding, lane geometry
// and the byte-lane insert helper used while assembling instruction words.
package instr_loader_pkg;

  localparam int BYTE_W = 8;
  localparam int LANES  = 4;
  localparam int WORD_W = BYTE_W * LANES;
  localparam int IDX_W  = $clog2(LANES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  // Return word with byte b placed in lane idx (lane 0 = bits 7:0).
  function automatic logic [WORD_W-1:0] put_lane(
    input logic [WORD_W-1:0] word,
    input logic [IDX_W-1:0]  idx,
    input logic [BYTE_W-1:0] b
  );
    logic [WORD_W-1:0] res;
    res = word;
    res[idx*BYTE_W +: BYTE_W] = b;
    return res;
  endfunction

endpackage

// File: rtl/instr_loader_edge_detect.sv
// Rising-edge detector for the host byte strobe. A level held high yields a
// single one-cycle pulse, in the same cycle the high level is first seen.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise
);

  logic sig_q_r;

  // Remember the strobe level from the previous clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q_r <= 1'b0;
    end else begin
      sig_q_r <= sig_in;
    end
  end

  assign rise = sig_in & ~sig_q_r;

endmodule

// File: rtl/instr_loader.sv
// Host-driven program loader: gathers strobed bytes into little-endian
// 32-bit words, writes them to instruction memory and holds the CPU in reset
// until loading is finished.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic              byte_strobe,
  input  logic [7:0]        byte_in,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic [ADDR_W:0]   word_count,
  output logic              overflow
);

  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(LANES - 1);

  state_e              state_r,  state_nxt;
  logic [IDX_W-1:0]    idx_r,    idx_nxt;
  logic [WORD_W-1:0]   asm_r,    asm_nxt;
  logic [ADDR_W-1:0]   addr_r,   addr_nxt;
  logic [ADDR_W:0]     cnt_r,    cnt_nxt;
  logic                ovf_r,    ovf_nxt;
  logic                we_r,     we_nxt;
  logic [ADDR_W-1:0]   maddr_r,  maddr_nxt;
  logic [WORD_W-1:0]   wdata_r,  wdata_nxt;
  logic                cpu_rst_n_r;
  logic                busy_r;

  logic                strobe_edge_s;
  logic                full_s;
  logic                last_s;
  logic                accept_s;
  logic [WORD_W-1:0]   lane_word_s;

  edge_detect u_edge_detect (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (byte_strobe),
    .rise   (strobe_edge_s)
  );

  // Memory is full once every address has been written once.
  assign full_s   = cnt_r[ADDR_W];
  assign last_s   = &addr_r;
  assign accept_s = strobe_edge_s & ~full_s;

  // Next-state and datapath decisions for the loader FSM.
  always_comb begin
    state_nxt   = state_r;
    idx_nxt     = idx_r;
    asm_nxt     = asm_r;
    addr_nxt    = addr_r;
    cnt_nxt     = cnt_r;
    ovf_nxt     = ovf_r;
    we_nxt      = 1'b0;
    maddr_nxt   = maddr_r;
    wdata_nxt   = wdata_r;
    lane_word_s = put_lane(asm_r, idx_r, byte_in);

    case (state_r)
      ST_IDLE, ST_RUN: begin
        if (load_en) begin
          state_nxt = ST_LOAD;
          idx_nxt   = '0;
          asm_nxt   = '0;
          addr_nxt  = '0;
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
        end else begin
          state_nxt = ST_RUN;
        end
      end

      ST_LOAD: begin
        if (strobe_edge_s && full_s) begin
          ovf_nxt = 1'b1;
        end else begin
          ovf_nxt = ovf_r;
        end
        if (accept_s) begin
          asm_nxt = lane_word_s;
          idx_nxt = idx_r + 1'b1;
        end else begin
          asm_nxt = asm_r;
          idx_nxt = idx_r;
        end
        // A full word, or a partial word left behind when loading stops,
        // goes out through one WRITE cycle; the assembly register restarts.
        if ((accept_s && (idx_r == LAST_LANE)) ||
            (!load_en && (accept_s || (idx_r != '0)))) begin
          state_nxt = ST_WRITE;
          we_nxt    = 1'b1;
          maddr_nxt = addr_r;
          wdata_nxt = accept_s ? lane_word_s : asm_r;
          asm_nxt   = '0;
          idx_nxt   = '0;
        end else if (!load_en) begin
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_LOAD;
        end
      end

      ST_WRITE: begin
        cnt_nxt  = cnt_r + 1'b1;
        addr_nxt = last_s ? addr_r : addr_r + 1'b1;
        // A byte arriving while the write is in flight starts the next word,
        // unless this write fills the last address.
        if (strobe_edge_s) begin
          if (last_s) begin
            ovf_nxt = 1'b1;
          end else begin
            asm_nxt = lane_word_s;
            idx_nxt = idx_r + 1'b1;
          end
        end else begin
          ovf_nxt = ovf_r;
        end
        state_nxt = load_en ? ST_LOAD : ST_RUN;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      idx_r       <= '0;
      asm_r       <= '0;
      addr_r      <= '0;
      cnt_r       <= '0;
      ovf_r       <= 1'b0;
      we_r        <= 1'b0;
      maddr_r     <= '0;
      wdata_r     <= '0;
      cpu_rst_n_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      idx_r       <= idx_nxt;
      asm_r       <= asm_nxt;
      addr_r      <= addr_nxt;
      cnt_r       <= cnt_nxt;
      ovf_r       <= ovf_nxt;
      we_r        <= we_nxt;
      maddr_r     <= maddr_nxt;
      wdata_r     <= wdata_nxt;
      cpu_rst_n_r <= (state_nxt == ST_RUN);
      busy_r      <= (state_nxt == ST_LOAD) || (state_nxt == ST_WRITE);
    end
  end

  assign mem_we     = we_r;
  assign mem_addr   = maddr_r;
  assign mem_wdata  = wdata_r;
  assign cpu_rst_n  = cpu_rst_n_r;
  assign busy       = busy_r;
  assign word_count = cnt_r;
  assign overflow   = ovf_r;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader (ADDR_W=2 so memory-full is reachable).
module tb_instr_loader;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_en;
  logic          byte_strobe;
  logic [7:0]    byte_in;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_rst_n;
  logic          busy;
  logic [AW:0]   word_count;
  logic          overflow;

  int total = 0;
  int bad   = 0;

  logic [AW+31:0] wq[$];
  logic [AW+31:0] exp_q[$];
  logic [7:0]     bytes_q[$];
  int             exp_cnt;
  logic           exp_ovf;
  logic           busy_load, rst_load, rst_after;
  int             dbl_we = 0;
  logic           we_prev = 1'b0;

  always #5 clk = ~clk;

  instr_loader #(.ADDR_W(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_en     (load_en),
    .byte_strobe (byte_strobe),
    .byte_in     (byte_in),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .cpu_rst_n   (cpu_rst_n),
    .busy        (busy),
    .word_count  (word_count),
    .overflow    (overflow)
  );

  // Record every memory write and any write pulse longer than one cycle.
  always @(negedge clk) begin
    if (mem_we) wq.push_back({mem_addr, mem_wdata});
    if (mem_we && we_prev) dbl_we++;
    we_prev = mem_we;
  end

  task automatic send(input logic [7:0] b, input int hold);
    @(negedge clk);
    byte_in = b;
    byte_strobe = 1'b1;
    repeat (hold) @(negedge clk);
    byte_strobe = 1'b0;
  endtask

  // Full load session of bytes_q, then drop load_en and let the CPU run.
  task automatic session(input int hold);
    @(negedge clk);
    wq.delete();
    load_en = 1'b1;
    @(negedge clk);
    busy_load = busy;
    rst_load = cpu_rst_n;
    foreach (bytes_q[i]) send(bytes_q[i], hold);
    @(negedge clk);
    load_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_after = cpu_rst_n;
    repeat (2) @(negedge clk);
  endtask

  // Reference: byte i goes to word i/4, lane i%4; words past memory end overflow.
  task automatic build_model();
    logic [31:0] w [1<<AW];
    int nw;
    for (int k = 0; k < (1 << AW); k++) w[k] = 32'h0;
    exp_ovf = 1'b0;
    foreach (bytes_q[i]) begin
      if (i / 4 < (1 << AW)) w[i/4] = w[i/4] | (32'(bytes_q[i]) << (8 * (i % 4)));
      else exp_ovf = 1'b1;
    end
    nw = (bytes_q.size() + 3) / 4;
    if (nw > (1 << AW)) nw = 1 << AW;
    exp_q.delete();
    for (int k = 0; k < nw; k++) exp_q.push_back({AW'(k), w[k]});
    exp_cnt = nw;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_en = 1'b0; byte_strobe = 1'b0; byte_in = 8'h00;
    repeat (3) @(negedge clk);
    total++; if ({mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, word_count, overflow} !== '0) begin
      bad++; $display("FAIL reset_outputs: got we=%b addr=%h data=%h cpu=%b busy=%b cnt=%0d ovf=%b want all zero",
                      mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, word_count, overflow); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (cpu_rst_n !== 1'b1) begin bad++; $display("FAIL idle_to_run: cpu_rst_n got %b want 1", cpu_rst_n); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_word();
    bytes_q = '{8'h13, 8'h05, 8'h10, 8'h00};
    session(1);
    total++; if (wq.size() !== 1) begin bad++; $display("FAIL single_nwrites: got %0d want 1", wq.size()); end
    total++; if (wq.size() > 0 && wq[0] !== {2'd0, 32'h00100513}) begin bad++; $display("FAIL single_write: got %h want %h", wq[0], {2'd0, 32'h00100513}); end
    total++; if (word_count !== 3'd1) begin bad++; $display("FAIL single_count: got %0d want 1", word_count); end
    total++; if (busy_load !== 1'b1 || rst_load !== 1'b0) begin bad++; $display("FAIL load_status: busy=%b cpu_rst_n=%b want 1 0", busy_load, rst_load); end
  endtask

  task automatic test_two_words();
    bytes_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    session(1);
    total++; if (wq.size() !== 2) begin bad++; $display("FAIL two_nwrites: got %0d want 2", wq.size()); end
    total++; if (wq.size() > 1 && (wq[0] !== {2'd0, 32'h04030201} || wq[1] !== {2'd1, 32'h08070605})) begin
      bad++; $display("FAIL two_writes: got %h %h want %h %h", wq[0], wq[1], {2'd0, 32'h04030201}, {2'd1, 32'h08070605}); end
    total++; if (rst_after !== 1'b1) begin bad++; $display("FAIL two_cpu_release: got %b want 1", rst_after); end
  endtask

  task automatic test_partial();
    bytes_q = '{8'hAA, 8'hBB};
    session(1);
    total++; if (wq.size() !== 1 || wq[0] !== {2'd0, 32'h0000BBAA}) begin
      bad++; $display("FAIL partial_write: got n=%0d first=%h want 1 %h", wq.size(), (wq.size() > 0) ? wq[0] : '0, {2'd0, 32'h0000BBAA}); end
    total++; if (word_count !== 3'd1 || rst_after !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL partial_run: cnt=%0d cpu=%b busy=%b want 1 1 0", word_count, rst_after, busy); end
  endtask

  task automatic test_held_strobe();
    bytes_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    session(10);
    total++; if (wq.size() !== 1 || wq[0] !== {2'd0, 32'h44332211}) begin
      bad++; $display("FAIL held_strobe: got n=%0d first=%h want 1 %h", wq.size(), (wq.size() > 0) ? wq[0] : '0, {2'd0, 32'h44332211}); end
  endtask

  // A one-cycle load_en dip flushes a partial word; a byte arriving in that
  // WRITE cycle must start the next word in lane 0.
  task automatic test_write_edge();
    @(negedge clk); wq.delete(); load_en = 1'b1;
    send(8'hA1, 1); send(8'hB2, 1);
    @(negedge clk); load_en = 1'b0;
    @(negedge clk); load_en = 1'b1; byte_in = 8'hC3; byte_strobe = 1'b1;
    @(negedge clk); byte_strobe = 1'b0;
    send(8'hD4, 1); send(8'hE5, 1); send(8'hF6, 1);
    @(negedge clk); load_en = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (wq.size() !== 2) begin bad++; $display("FAIL wedge_nwrites: got %0d want 2", wq.size()); end
    total++; if (wq.size() > 1 && (wq[0] !== {2'd0, 32'h0000B2A1} || wq[1] !== {2'd1, 32'hF6E5D4C3})) begin
      bad++; $display("FAIL wedge_writes: got %h %h want %h %h", wq[0], wq[1], {2'd0, 32'h0000B2A1}, {2'd1, 32'hF6E5D4C3}); end
    total++; if (word_count !== 3'd2) begin bad++; $display("FAIL wedge_count: got %0d want 2", word_count); end
  endtask

  task automatic test_overflow();
    bytes_q.delete();
    for (int i = 0; i < 17; i++) bytes_q.push_back(8'($urandom));
    build_model();
    session(1);
    total++; if (wq.size() !== 4) begin bad++; $display("FAIL ovf_nwrites: got %0d want 4", wq.size()); end
    foreach (exp_q[i]) begin
      total++; if (i < wq.size() && wq[i] !== exp_q[i]) begin bad++; $display("FAIL ovf_write%0d: got %h want %h", i, wq[i], exp_q[i]); end
    end
    total++; if (overflow !== 1'b1 || word_count !== 3'd4) begin bad++; $display("FAIL ovf_flags: ovf=%b cnt=%0d want 1 4", overflow, word_count); end
  endtask

  task automatic test_reset_midword();
    @(negedge clk); wq.delete(); load_en = 1'b1;
    send(8'h5A, 1); send(8'hC7, 1);
    @(negedge clk); rst_n = 1'b0;
    #1;
    total++; if ({mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, word_count, overflow} !== '0) begin
      bad++; $display("FAIL async_reset: got we=%b addr=%h data=%h cpu=%b busy=%b cnt=%0d ovf=%b want all zero",
                      mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, word_count, overflow); end
    load_en = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (wq.size() !== 0) begin bad++; $display("FAIL reset_nowrite: got %0d writes want 0", wq.size()); end
    bytes_q = '{8'h9C, 8'h8D, 8'h7E, 8'h6F};
    session(1);
    total++; if (wq.size() !== 1 || wq[0] !== {2'd0, 32'h6F7E8D9C}) begin
      bad++; $display("FAIL reload_write: got n=%0d first=%h want 1 %h", wq.size(), (wq.size() > 0) ? wq[0] : '0, {2'd0, 32'h6F7E8D9C}); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int n, hold;
      n = $urandom_range(1, 20);
      hold = $urandom_range(1, 3);
      bytes_q.delete();
      for (int i = 0; i < n; i++) bytes_q.push_back(8'($urandom));
      build_model();
      session(hold);
      total++; if (wq.size() !== exp_q.size()) begin bad++; $display("FAIL rand%0d_nwrites: got %0d want %0d", it, wq.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
        total++; if (i < wq.size() && wq[i] !== exp_q[i]) begin bad++; $display("FAIL rand%0d_write%0d: got %h want %h", it, i, wq[i], exp_q[i]); end
      end
      total++; if (word_count !== (AW+1)'(exp_cnt) || overflow !== exp_ovf) begin
        bad++; $display("FAIL rand%0d_status: cnt=%0d ovf=%b want %0d %b", it, word_count, overflow, exp_cnt, exp_ovf); end
      total++; if (rst_after !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rand%0d_run: cpu=%b busy=%b want 1 0", it, rst_after, busy); end
    end
    total++; if (dbl_we !== 0) begin bad++; $display("FAIL we_pulse_width: got %0d long pulses want 0", dbl_we); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_two_words();
    test_partial();
    test_held_strobe();
    test_write_edge();
    test_overflow();
    test_reset_midword();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
